mmio_uart: RTL and testbench
============================

Name: mmio_uart

Overview:
- Memory-mapped UART on the physical memory bus driven by mem_controller, alongside iram/irom.
- Decodes its own address window and returns read data on its own HRDATA, which is zero when not selected so the top level can OR it with the RAM/ROM return.
- TX path: FIFO plus serialiser. RX path: synchroniser plus deserialiser.
- Used for console I/O by code running on the pipeline.

Parameters:
- BASE_ADDR, 64'h0000_0000_1000_0000: window base, 32-byte aligned.
- TX_DEPTH, 8: TX FIFO entries; power of two, 2..64.
- DIV_W, 16: width of the bit-period divisor.
- DIV_RESET, 434: divisor after reset, in CLK cycles per bit.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset; asynchronous, active-low.
- HWRITE  in  1  bus write strobe from mem_controller.
- PADDR  in  64  bus address.
- PDATA  in  64  bus write data.
- HRDATA  out  64  read data; zero when not selected.
- TXD  out  1  serial transmit line; idle high.
- RXD  in  1  serial receive line; asynchronous to CLK.

Behaviour:
- Select: sel = (PADDR[63:5] == BASE_ADDR[63:5]). Register offset = PADDR[4:3]. PADDR[2:0] ignored.
- Writes take effect at the CLK posedge when sel & HWRITE.
- Reads are combinational: HRDATA = register value when sel & !HWRITE, else 64'h0. Reads have no side effects.
- Register map:
  - 0x00 TXDATA (W): push PDATA[7:0]. If the FIFO is full the byte is dropped and TX_OVF is set. Reads return 0.
  - 0x08 RXDATA (R): {56'b0, rx_byte}. Writes are ignored.
  - 0x10 STATUS:
    - bit0 TX_FULL, bit1 TX_EMPTY, bit2 TX_BUSY (FSM not IDLE), bit3 RX_VALID.
    - Sticky bits: bit4 RX_OVR, bit5 TX_OVF, bit6 RX_FERR.
    - Writing 1 to bits 3..6 clears them (W1C). Clearing bit3 pops the RX byte.
    - Writing 0 to any bit has no effect.
  - 0x18 DIVISOR (R/W): [DIV_W-1:0]. Written values below 2 are stored as 2. A new value is latched by TX/RX only at the next frame start.
- Reset values:
  - TXD=1.
  - FIFO empty: TX_EMPTY=1, TX_FULL=0.
  - All other status bits 0; rx_byte=0; DIVISOR=DIV_RESET; both FSMs IDLE.
  - Reset mid-frame aborts the frame immediately (asynchronous): TXD goes to 1 and the FIFO is emptied.
- TX FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push and pop in the same cycle when full: both take effect, count unchanged, no overflow.
  - Push when empty with pop requested: no pop happens that cycle.
- TX FSM, states IDLE, START, DATA, STOP:
  - Bit counter runs from div-1 down to 0 per bit.
  - IDLE: when the FIFO is non-empty, pop, load the shifter, latch div, drive TXD=0, go to START.
  - START: after div cycles go to DATA.
  - DATA: 8 bits, LSB first, div cycles each, then STOP.
  - STOP: TXD=1 for div cycles, then IDLE.
  - Frame length = 10*div cycles. The next frame's start bit begins 1 cycle after STOP ends (back-to-back).
- RX:
  - RXD passes through a 2-flop synchroniser, reset value 1.
  - FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: falling edge of the synchronised line -> START, latch div.
  - START: at div/2 cycles sample the line. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample 8 bits every div cycles, LSB first.
  - STOP: sample after div cycles.
    - Stop bit = 1 and RX_VALID = 0: store rx_byte, set RX_VALID.
    - Stop bit = 1 and RX_VALID = 1: discard the new byte, set RX_OVR.
    - Stop bit = 0: discard the byte, set RX_FERR, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the line is 1, then IDLE.
  - If a W1C clear of RX_VALID and a new byte arriving land in the same cycle, the new byte wins: RX_VALID=1, rx_byte is updated, and RX_OVR is not set.

Optional Feature:
- Macro UART_RX_EN.
- Defined: the RX synchroniser, RX FSM, RXDATA register and bits 3, 4 and 6 are built.
- Undefined: RXD is unused, RXDATA reads 0, STATUS bits 3, 4 and 6 read 0 and writes to them are ignored. The TX path is unchanged.

Test Plan:
- Reset then read 0x10 -> HRDATA=64'h2. Read 0x18 -> HRDATA=434. TXD=1.
- DIVISOR=4, write 0x55 to TXDATA -> TXD low for cycles 1..4 after the write, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high. TX_BUSY=1 for 40 cycles.
- DIVISOR=2, burst of 9 writes with TX_DEPTH=8 -> first byte moves to the shifter, so all 9 are accepted and TX_OVF=0. A 10th write immediately after -> TX_OVF=1. Write 0x20 to 0x10 -> TX_OVF=0.
- DIVISOR=4, drive RXD with frame 0xA3 (8N1) -> RX_VALID=1 and RXDATA=0xA3. Second frame 0x11 before clear -> RX_OVR=1 and RXDATA stays 0xA3.
- RXD frame with stop bit 0 -> RX_FERR=1, RX_VALID=0. A 1-cycle low glitch on idle RXD -> no state change.
- Assert RESET mid-TX frame -> TXD=1 within the same cycle. After release, STATUS=0x2 and the FIFO is empty.

Source files
------------

// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped UART with a TX FIFO and serialiser, plus an optional RX deserialiser.
// Define UART_RX_EN to build the RX path; without it RXDATA and STATUS bits 3, 4 and 6 read 0.
module mmio_uart #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1000_0000,
  parameter int TX_DEPTH = 8,
  parameter int DIV_W = 16,
  parameter int DIV_RESET = 434
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HWRITE,
  input  logic [63:0] PADDR,
  input  logic [63:0] PDATA,
  output logic [63:0] HRDATA,
  output logic        TXD,
  input  logic        RXD
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;

  logic             w_sel, w_wr, w_unused;
  logic [1:0]       w_off;
  logic [6:3]       w_clr;
  logic [DIV_W-1:0] w_div_in, r_div;
  logic [63:0]      w_status;
  logic             w_st_valid, w_st_ovr, w_st_ferr;
  logic [7:0]       w_rx_data;

  assign w_sel    = PADDR[63:5] == BASE_ADDR[63:5];
  assign w_off    = PADDR[4:3];
  assign w_wr     = w_sel && HWRITE;
  assign w_clr    = (w_wr && w_off == 2'd2) ? PDATA[6:3] : 4'b0;
  assign w_div_in = (PDATA[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : PDATA[DIV_W-1:0];
  assign w_unused = ^{PADDR[2:0], PDATA[63:DIV_W], RXD, w_clr};

  // Bit-period divisor; values below 2 are clamped so a half-bit count is never zero
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) r_div <= DIV_W'(DIV_RESET);
    else if (w_wr && w_off == 2'd3) r_div <= w_div_in;

  logic [7:0]    r_mem [TX_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_full, w_empty, w_push_req, w_push, w_pop, w_ovf, r_tx_ovf;

  assign w_full     = r_cnt == (AW+1)'(TX_DEPTH);
  assign w_empty    = r_cnt == '0;
  assign w_push_req = w_wr && w_off == 2'd0;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf      = w_push_req && w_full && !w_pop;

  // FIFO storage; a full FIFO still accepts a push when the serialiser pops the same cycle
  always_ff @(posedge CLK)
    if (w_push) r_mem[r_wp] <= PDATA[7:0];

  // FIFO pointers and occupancy; reset empties the FIFO
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end

  // Sticky TX overflow flag, set wins over a same-cycle clear
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) r_tx_ovf <= 1'b0;
    else r_tx_ovf <= w_ovf || (r_tx_ovf && !w_clr[5]);

  logic [1:0]       r_tx_st, w_tx_nx;
  logic [DIV_W-1:0] r_tx_cnt, r_tx_div;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_sh;
  logic             w_tx_end;

  assign w_tx_end = r_tx_cnt == '0;

  // TX state register and bit-timing datapath; the divisor is frozen per frame
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_div <= DIV_W'(DIV_RESET);
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
    end else begin
      r_tx_st <= w_tx_nx;
      if (w_pop) begin
        r_tx_sh  <= r_mem[r_rp];
        r_tx_div <= r_div;
        r_tx_cnt <= r_div - 1'b1;
        r_tx_bit <= '0;
      end else if (r_tx_st != TX_IDLE) begin
        r_tx_cnt <= w_tx_end ? r_tx_div - 1'b1 : r_tx_cnt - 1'b1;
        if (w_tx_end && r_tx_st == TX_DATA) begin
          r_tx_sh  <= r_tx_sh >> 1;
          r_tx_bit <= r_tx_bit + 1'b1;
        end
      end
    end

  // TX next state: each state lasts one full bit period
  always_comb begin
    w_tx_nx = r_tx_st;
    case (r_tx_st)
      TX_IDLE:  if (!w_empty) w_tx_nx = TX_START;
      TX_START: if (w_tx_end) w_tx_nx = TX_DATA;
      TX_DATA:  if (w_tx_end && r_tx_bit == 3'd7) w_tx_nx = TX_STOP;
      default:  if (w_tx_end) w_tx_nx = TX_IDLE;
    endcase
  end

  // TX outputs: pop on frame start, line driven straight from state so reset forces it high
  always_comb begin
    w_pop = r_tx_st == TX_IDLE && !w_empty;
    TXD   = r_tx_st == TX_START ? 1'b0 : r_tx_st == TX_DATA ? r_tx_sh[0] : 1'b1;
  end

`ifdef UART_RX_EN
  localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_WAIT = 3'd4;

  logic             r_rx_s1, r_rx_s2, r_rx_s3;
  logic [2:0]       r_rx_st, w_rx_nx, r_rx_bit;
  logic [DIV_W-1:0] r_rx_cnt, r_rx_div;
  logic [7:0]       r_rx_sh, r_rx_byte;
  logic             r_rx_valid, r_rx_ovr, r_rx_ferr;
  logic             w_rx_end, w_rx_done, w_rx_bad;

  assign w_rx_end = r_rx_cnt == '0;

  // Two-flop synchroniser plus a history flop for falling-edge detection
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= RXD;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end

  // RX state register and sampling datapath; the first count is half a bit to hit mid-bit
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      r_rx_st  <= RX_IDLE;
      r_rx_cnt <= '0;
      r_rx_div <= DIV_W'(DIV_RESET);
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
    end else begin
      r_rx_st <= w_rx_nx;
      if (r_rx_st == RX_IDLE) begin
        r_rx_div <= r_div;
        r_rx_cnt <= (r_div >> 1) - 1'b1;
        r_rx_bit <= '0;
      end else if (r_rx_st != RX_WAIT) begin
        r_rx_cnt <= w_rx_end ? r_rx_div - 1'b1 : r_rx_cnt - 1'b1;
        if (w_rx_end && r_rx_st == RX_DATA) begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 1'b1;
        end
      end
    end

  // RX next state: glitches abort in START, framing errors wait for the line to recover
  always_comb begin
    w_rx_nx = r_rx_st;
    case (r_rx_st)
      RX_IDLE:  if (r_rx_s3 && !r_rx_s2) w_rx_nx = RX_START;
      RX_START: if (w_rx_end) w_rx_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_end && r_rx_bit == 3'd7) w_rx_nx = RX_STOP;
      RX_STOP:  if (w_rx_end) w_rx_nx = r_rx_s2 ? RX_IDLE : RX_WAIT;
      default:  if (r_rx_s2) w_rx_nx = RX_IDLE;
    endcase
  end

  // RX outputs: frame completion with a good or bad stop bit
  always_comb begin
    w_rx_done = r_rx_st == RX_STOP && w_rx_end && r_rx_s2;
    w_rx_bad  = r_rx_st == RX_STOP && w_rx_end && !r_rx_s2;
  end

  // RX flags; a byte landing with a same-cycle clear of RX_VALID is kept, not counted as overrun
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_byte  <= '0;
    end else begin
      r_rx_valid <= w_rx_done || (r_rx_valid && !w_clr[3]);
      r_rx_ovr   <= (w_rx_done && r_rx_valid && !w_clr[3]) || (r_rx_ovr && !w_clr[4]);
      r_rx_ferr  <= w_rx_bad || (r_rx_ferr && !w_clr[6]);
      if (w_rx_done && (!r_rx_valid || w_clr[3])) r_rx_byte <= r_rx_sh;
    end

  assign w_st_valid = r_rx_valid;
  assign w_st_ovr   = r_rx_ovr;
  assign w_st_ferr  = r_rx_ferr;
  assign w_rx_data  = r_rx_byte;
`else
  assign w_st_valid = 1'b0;
  assign w_st_ovr   = 1'b0;
  assign w_st_ferr  = 1'b0;
  assign w_rx_data  = 8'h0;
`endif

  assign w_status = {57'b0, w_st_ferr, r_tx_ovf, w_st_ovr, w_st_valid, r_tx_st != TX_IDLE, w_empty, w_full};

  // Read mux; zero when not selected so the top level can OR this with memory read data
  always_comb
    HRDATA = !(w_sel && !HWRITE) ? 64'h0 :
             w_off == 2'd0 ? 64'h0 :
             w_off == 2'd1 ? {56'b0, w_rx_data} :
             w_off == 2'd2 ? w_status : {{(64-DIV_W){1'b0}}, r_div};
endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: directed bench for mmio_uart covering registers, TX timing, FIFO limits, RX and reset.
module tb_mmio_uart;
  localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
  localparam logic [63:0] A_TX  = BASE;
  localparam logic [63:0] A_RX  = BASE + 64'h8;
  localparam logic [63:0] A_ST  = BASE + 64'h10;
  localparam logic [63:0] A_DIV = BASE + 64'h18;

  logic        CLK = 1'b0, RESET = 1'b0, HWRITE = 1'b0, RXD = 1'b1;
  logic        TXD;
  logic [63:0] PADDR = 64'h0, PDATA = 64'h0, HRDATA;
  int          errors = 0, checks = 0, cyc = 0;

  mmio_uart dut (
    .CLK(CLK), .RESET(RESET), .HWRITE(HWRITE), .PADDR(PADDR),
    .PDATA(PDATA), .HRDATA(HRDATA), .TXD(TXD), .RXD(RXD)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    @(negedge CLK);
    HWRITE = 1'b1; PADDR = a; PDATA = d;
    @(posedge CLK); #1;
    HWRITE = 1'b0; PADDR = 64'h0; PDATA = 64'h0;
  endtask

  task automatic rd(input logic [63:0] a, output logic [63:0] d);
    HWRITE = 1'b0; PADDR = a;
    #1 d = HRDATA;
    PADDR = 64'h0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge CLK); RXD = 1'b0;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (4) @(negedge CLK);
    end
    RXD = stop;
    repeat (4) @(negedge CLK);
    RXD = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  task automatic capture(output logic [7:0] b, output logic stop, output int t);
    int n = 0;
    while (TXD !== 1'b0 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL tx_start_timeout: TXD=%b want 0 within 200 cycles", TXD); end
    t = cyc;
    repeat (6) @(posedge CLK);
    #1 b[0] = TXD;
    for (int i = 1; i < 8; i++) begin
      repeat (4) @(posedge CLK);
      #1 b[i] = TXD;
    end
    repeat (4) @(posedge CLK);
    #1 stop = TXD;
  endtask

  task automatic test_reset;
    logic [63:0] d;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd_held: got %b want 1", TXD); end
    @(negedge CLK); RESET = 1'b1;
    rd(A_ST, d);
    checks++; if (d !== 64'h2) begin errors++; $display("FAIL reset_status: got %h want 2", d); end
    rd(A_DIV, d);
    checks++; if (d !== 64'd434) begin errors++; $display("FAIL reset_div: got %0d want 434", d); end
    rd(A_RX, d);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL reset_rxdata: got %h want 0", d); end
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", TXD); end
    @(negedge CLK);
    rd(BASE + 64'h30, d);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL unselected_above: got %h want 0", d); end
    rd(BASE - 64'h8, d);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL unselected_below: got %h want 0", d); end
    @(negedge CLK);
    HWRITE = 1'b1; PADDR = A_DIV; PDATA = 64'h0;
    #1;
    checks++; if (HRDATA !== 64'h0) begin errors++; $display("FAIL read_during_write: got %h want 0", HRDATA); end
    HWRITE = 1'b0; PADDR = 64'h0;
  endtask

  task automatic test_divisor;
    logic [63:0] d;
    wr(A_DIV, 64'd0);
    rd(A_DIV, d);
    checks++; if (d !== 64'd2) begin errors++; $display("FAIL div_clamp0: got %0d want 2", d); end
    wr(A_DIV, 64'd1);
    rd(A_DIV, d);
    checks++; if (d !== 64'd2) begin errors++; $display("FAIL div_clamp1: got %0d want 2", d); end
    wr(A_DIV, 64'hFFFF_0007);
    rd(A_DIV, d);
    checks++; if (d !== 64'd7) begin errors++; $display("FAIL div_width: got %0d want 7", d); end
  endtask

  task automatic test_tx_frame;
    logic [63:0] d;
    logic [7:0]  b;
    logic        e;
    b = 8'h55;
    wr(A_DIV, 64'd4);
    wr(A_TX, 64'h155);
    rd(A_ST, d);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL tx_after_push_status: got %h want 0", d); end
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL tx_after_push_txd: got %b want 1", TXD); end
    for (int k = 1; k <= 41; k++) begin
      @(posedge CLK); #1;
      if (k <= 4) e = 1'b0;
      else if (k <= 36) e = b[(k-5)/4];
      else e = 1'b1;
      rd(A_ST, d);
      checks++; if (TXD !== e) begin errors++; $display("FAIL tx_bit cycle %0d: got %b want %b", k, TXD, e); end
      checks++; if (d[2] !== (k <= 40)) begin errors++; $display("FAIL tx_busy cycle %0d: got %b want %b", k, d[2], k <= 40); end
    end
    rd(A_ST, d);
    checks++; if (d !== 64'h2) begin errors++; $display("FAIL tx_done_status: got %h want 2", d); end
  endtask

  task automatic test_burst_ovf;
    logic [63:0] d;
    logic        done;
    wr(A_DIV, 64'd2);
    for (int i = 0; i < 9; i++) wr(A_TX, 64'hF0 + 64'(i));
    rd(A_ST, d);
    checks++; if (d !== 64'h5) begin errors++; $display("FAIL burst9_status: got %h want 5", d); end
    wr(A_TX, 64'hEE);
    rd(A_ST, d);
    checks++; if (d !== 64'h25) begin errors++; $display("FAIL burst10_ovf: got %h want 25", d); end
    wr(A_ST, 64'h0);
    rd(A_ST, d);
    checks++; if (d !== 64'h25) begin errors++; $display("FAIL w0_no_effect: got %h want 25", d); end
    wr(A_ST, 64'h20);
    rd(A_ST, d);
    checks++; if (d !== 64'h5) begin errors++; $display("FAIL ovf_w1c: got %h want 5", d); end
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge CLK); #1;
      rd(A_ST, d);
      done = d == 64'h2;
    end
    checks++; if (!done) begin errors++; $display("FAIL burst_drain: status %h want 2 within 400 cycles", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b1, b2, b3;
    logic       s1, s2, s3;
    int         t1, t2, t3;
    wr(A_DIV, 64'd4);
    wr(A_TX, 64'h3C);
    wr(A_TX, 64'hA5);
    wr(A_TX, 64'h0F);
    capture(b1, s1, t1);
    capture(b2, s2, t2);
    capture(b3, s3, t3);
    checks++; if (b1 !== 8'h3C) begin errors++; $display("FAIL b2b_byte1: got %h want 3c", b1); end
    checks++; if (b2 !== 8'hA5) begin errors++; $display("FAIL b2b_byte2: got %h want a5", b2); end
    checks++; if (b3 !== 8'h0F) begin errors++; $display("FAIL b2b_byte3: got %h want 0f", b3); end
    checks++; if ({s1, s2, s3} !== 3'b111) begin errors++; $display("FAIL b2b_stop: got %b want 111", {s1, s2, s3}); end
    checks++; if (t3 - t2 !== 41) begin errors++; $display("FAIL b2b_gap: got %0d want 41", t3 - t2); end
  endtask

`ifdef UART_RX_EN
  task automatic test_rx;
    logic [63:0] d;
    wr(A_DIV, 64'd4);
    send_rx(8'hA3, 1'b1);
    rd(A_ST, d);
    checks++; if (d !== 64'h0A) begin errors++; $display("FAIL rx_valid: got %h want 0a", d); end
    rd(A_RX, d);
    checks++; if (d !== 64'hA3) begin errors++; $display("FAIL rx_data: got %h want a3", d); end
    send_rx(8'h11, 1'b1);
    rd(A_ST, d);
    checks++; if (d !== 64'h1A) begin errors++; $display("FAIL rx_ovr: got %h want 1a", d); end
    rd(A_RX, d);
    checks++; if (d !== 64'hA3) begin errors++; $display("FAIL rx_ovr_keep: got %h want a3", d); end
    wr(A_ST, 64'h18);
    rd(A_ST, d);
    checks++; if (d !== 64'h02) begin errors++; $display("FAIL rx_clear: got %h want 02", d); end
    send_rx(8'h5A, 1'b0);
    rd(A_ST, d);
    checks++; if (d !== 64'h42) begin errors++; $display("FAIL rx_ferr: got %h want 42", d); end
    wr(A_ST, 64'h40);
    rd(A_ST, d);
    checks++; if (d !== 64'h02) begin errors++; $display("FAIL rx_ferr_clear: got %h want 02", d); end
    @(negedge CLK); RXD = 1'b0;
    @(negedge CLK); RXD = 1'b1;
    repeat (12) @(negedge CLK);
    rd(A_ST, d);
    checks++; if (d !== 64'h02) begin errors++; $display("FAIL rx_glitch: got %h want 02", d); end
    send_rx(8'h3C, 1'b1);
    rd(A_RX, d);
    checks++; if (d !== 64'h3C) begin errors++; $display("FAIL rx_after_glitch: got %h want 3c", d); end
    wr(A_ST, 64'h08);
    rd(A_ST, d);
    checks++; if (d !== 64'h02) begin errors++; $display("FAIL rx_pop: got %h want 02", d); end
  endtask
`else
  task automatic test_rx_disabled;
    logic [63:0] d;
    wr(A_DIV, 64'd4);
    send_rx(8'hA3, 1'b1);
    rd(A_ST, d);
    checks++; if (d !== 64'h02) begin errors++; $display("FAIL norx_status: got %h want 02", d); end
    rd(A_RX, d);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL norx_data: got %h want 0", d); end
    wr(A_ST, 64'h58);
    rd(A_ST, d);
    checks++; if (d !== 64'h02) begin errors++; $display("FAIL norx_w1c: got %h want 02", d); end
  endtask
`endif

  task automatic test_reset_mid_frame;
    logic [63:0] d;
    wr(A_DIV, 64'd4);
    wr(A_TX, 64'h00);
    wr(A_TX, 64'h81);
    wr(A_TX, 64'h42);
    repeat (10) @(posedge CLK);
    #1;
    rd(A_ST, d);
    checks++; if (TXD !== 1'b0) begin errors++; $display("FAIL midframe_txd: got %b want 0", TXD); end
    checks++; if (d[2] !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b want 1", d[2]); end
    RESET = 1'b0;
    #1;
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL async_reset_txd: got %b want 1", TXD); end
    @(negedge CLK); RESET = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL post_reset_idle cycle %0d: got %b want 1", k, TXD); end
    end
    rd(A_ST, d);
    checks++; if (d !== 64'h2) begin errors++; $display("FAIL post_reset_status: got %h want 2", d); end
    rd(A_DIV, d);
    checks++; if (d !== 64'd434) begin errors++; $display("FAIL post_reset_div: got %0d want 434", d); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_divisor;
    test_tx_frame;
    test_burst_ovf;
    test_back_to_back;
`ifdef UART_RX_EN
    test_rx;
`else
    test_rx_disabled;
`endif
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
